decode_stage_buf: RTL and testbench
===================================

# decode_stage_buf

Parametrised D-stage for the five-stage MIPS pipeline: a DEPTH-entry instruction buffer fed by F, a full instruction decoder, a Tuse/Tnew stall unit and the registered D/E pipeline register with valid/ready handshakes on both sides. It sits between the fetch unit and the E-stage ALU. Beyond a plain decoder, it:
- buffers fetched instructions,
- stalls on hazards by itself,
- absorbs back-pressure from E,
- flushes on redirect.

## Interface
- DEPTH, 4, buffer entries; power of two, ≥2
- PC_W, 32, PC width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- f_valid  in  1  F offers an instruction
- f_ready  out  1  buffer not full
- f_instr  in  32  instruction word
- f_pc  in  PC_W  its PC
- flush  in  1  synchronous redirect: discard buffer and D/E register
- m_wr  in  1  M-stage instruction writes GRF
- m_a3  in  5  M-stage destination
- m_tnew  in  2  M-stage cycles until result available
- d_valid  out  1  D/E register holds an instruction
- d_ready  in  1  E accepts it
- d_instr  out  32  registered instruction
- d_pc  out  PC_W  registered PC
- d_rs, d_rt, d_a3  out  5 each  source and destination fields
- d_rfwr  out  1  GRF write enable
- d_tnew  out  2  Tnew at E
- d_onehot  out  NINS  one-hot instruction class
- d_illegal  out  1  undecodable instruction
- stall  out  1  head blocked by hazard

## Operation
- Buffer is a circular FIFO:
  - Push when f_valid && f_ready.
  - Head is decoded combinationally.
  - f_ready = (count != DEPTH).
- Decode, base set, d_onehot order LSB→MSB: addu, subu, ori, lui, addi, lw, lh, lb, sw, sh, sb, beq, j, jal, jalr, jr, sll.
  - NINS = 17.
  - R-type matches require opcode 0.
- A3 and write enable:
  - rd for addu/subu/sll/jalr.
  - rt for ori/lui/addi/loads.
  - 31 for jal.
  - Otherwise 0.
  - d_rfwr = (A3 != 0).
  - Instruction 0x00000000 decodes as sll with A3=0, so no write.
- Tuse:
  - rs: 0 for beq/jr/jalr; 1 for ALU, load and store.
  - rt: 0 for beq; 1 for addu/subu/sll; 2 for stores.
  - Other sources unused.
- Tnew at E: loads 2; ALU/lui 1; jal/jalr 0.
- Hazard on a used source s ≠ 0 when either holds:
  - d_valid && d_rfwr && d_a3 == s && d_tnew > Tuse.
  - m_wr && m_a3 == s && m_tnew > Tuse.
  - Otherwise stall = 0.
- Pop/load: head moves into D/E register when head valid && !stall && (!d_valid || d_ready).
- If E takes the D/E entry but nothing new is loaded, d_valid falls to 0. This is a bubble.
- Illegal instruction:
  - d_illegal = 1, d_rfwr = 0, d_onehot = 0.
  - It still flows through.
- flush has priority over push, pop and load:
  - Next edge sets count = 0 and d_valid = 0.
  - f_instr offered in the flush cycle is dropped.

## Timing
- Reset values:
  - All registered outputs 0; d_valid 0.
  - Buffer empty, so f_ready 1 and stall 0.
- Latency: f_valid accepted at edge N into an empty buffer with E ready → d_valid at edge N+1.
- Full buffer:
  - f_ready = 0 in that cycle even if a pop happens in the same cycle.
  - No combinational path from d_ready to f_ready.
- Empty buffer with simultaneous push: head is not valid until the following cycle; no bypass.
- Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
- d_ready low holds all d_* stable.
- stall is combinational from head, D/E register and m_* inputs.
- Asynchronous reset mid-transfer discards everything immediately.

## Configuration
- DECODE_EXT_EN defined:
  - Adds and, or, slt, sltu (R-type ALU) and andi, bne, sra, above the base set.
  - NINS = 24; Tuse/Tnew as for ALU and beq equivalents.
- DECODE_EXT_EN undefined:
  - NINS = 17.
  - Those encodings raise d_illegal.

## Test plan
- Push lw $8,0($9) then addu $10,$8,$11 with d_ready=1, M stage empty:
  - addu stalls exactly 1 cycle.
  - d_onehot[0] at output two edges after lw.
- beq $1,$2 with m_wr=1, m_a3=1, m_tnew=1 → stall=1 until m_tnew=0.
- Fill DEPTH=4 with d_ready=0 → f_ready=0 after 4+1 accepted words.
  - 4 buffered plus 1 in the D/E register.
  - Release d_ready → original order out, wrap-around intact.
- flush with buffer holding 3 entries and f_valid=1 → next cycle: count 0, d_valid 0, flushed word absent.
- jal then jr $31 → d_a3=31, d_tnew=0 for jal; jr has no stall, d_rfwr=0.
- 0x00000000 → d_rfwr=0, d_illegal=0.
- With DECODE_EXT_EN off, and $1,$2,$3 → d_illegal=1.

Source files
------------

// File: rtl/decode_stage_buf.sv
// ---------------------------------------------------------------------------
// decode_stage_buf
//
// D-stage of the five-stage MIPS pipeline.  Instructions from F are held in
// a DEPTH-entry circular buffer.  The head entry is decoded combinationally
// and checked for hazards (Tuse/Tnew) against the D/E register and the M
// stage.  When it is clear and E can take a new entry, the head moves into
// the registered D/E pipeline register.
//
// Optional feature macro: DECODE_EXT_EN
//   When defined, the decoder also accepts and, or, slt, sltu, andi, bne and
//   sra, and d_onehot grows from 17 to 24 bits.  When undefined, those
//   encodings decode as illegal.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   f_valid/f_ready     F-side handshake; f_ready is high while not full
//   f_instr, f_pc       instruction word and its PC offered by F
//   flush               synchronous redirect, empties buffer and D/E reg
//   m_wr, m_a3, m_tnew  M-stage write enable, destination and Tnew
//   d_valid/d_ready     E-side handshake for the D/E register
//   d_instr, d_pc       registered instruction and PC
//   d_rs, d_rt, d_a3    source and destination register fields
//   d_rfwr, d_tnew      GRF write enable and Tnew at E
//   d_onehot            one-hot instruction class
//   d_illegal           undecodable instruction
//   stall               head of buffer blocked by a hazard
// ---------------------------------------------------------------------------
module decode_stage_buf #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32,
`ifdef DECODE_EXT_EN
    localparam int NINS = 24
`else
    localparam int NINS = 17
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            f_valid,
    output logic            f_ready,
    input  logic [31:0]     f_instr,
    input  logic [PC_W-1:0] f_pc,
    input  logic            flush,
    input  logic            m_wr,
    input  logic [4:0]      m_a3,
    input  logic [1:0]      m_tnew,
    output logic            d_valid,
    input  logic            d_ready,
    output logic [31:0]     d_instr,
    output logic [PC_W-1:0] d_pc,
    output logic [4:0]      d_rs,
    output logic [4:0]      d_rt,
    output logic [4:0]      d_a3,
    output logic            d_rfwr,
    output logic [1:0]      d_tnew,
    output logic [NINS-1:0] d_onehot,
    output logic            d_illegal,
    output logic            stall
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]     mem_instr [DEPTH];
    logic [PC_W-1:0] mem_pc    [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;

    logic            head_valid, push, pop;
    logic [31:0]     h_instr;
    logic [5:0]      opcode, funct;
    logic [4:0]      rs, rt, rd;

    logic [NINS-1:0] onehot;
    logic            illegal;
    logic            alu_r, shift, alu_i, is_lui, load, store, br, is_jal, is_jalr, is_jr;
    logic [4:0]      a3;
    logic [1:0]      tnew, tuse_rs, tuse_rt;
    logic            use_rs, use_rt, rfwr;
    logic            haz_rs, haz_rt;

    // f_ready comes from the registered count only, so d_ready never
    // reaches it combinationally; a full buffer refuses F even on a pop.
    assign f_ready    = (count != CW'(DEPTH));
    assign head_valid = (count != '0);
    assign push       = f_valid && f_ready && !flush;
    assign pop        = head_valid && !stall && (!d_valid || d_ready) && !flush;

    assign h_instr = mem_instr[rd_ptr];
    assign opcode  = h_instr[31:26];
    assign rs      = h_instr[25:21];
    assign rt      = h_instr[20:16];
    assign rd      = h_instr[15:11];
    assign funct   = h_instr[5:0];

    // Storage carries no reset: count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= f_instr;
            mem_pc[wr_ptr]    <= f_pc;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Instruction class decode; R-type entries require opcode 0.
    always_comb begin
        onehot = '0;
        if (opcode == 6'h00) begin
            case (funct)
                6'h21: onehot[0]  = 1'b1;
                6'h23: onehot[1]  = 1'b1;
                6'h09: onehot[14] = 1'b1;
                6'h08: onehot[15] = 1'b1;
                6'h00: onehot[16] = 1'b1;
`ifdef DECODE_EXT_EN
                6'h24: onehot[17] = 1'b1;
                6'h25: onehot[18] = 1'b1;
                6'h2a: onehot[19] = 1'b1;
                6'h2b: onehot[20] = 1'b1;
                6'h03: onehot[23] = 1'b1;
`endif
                default: ;
            endcase
        end else begin
            case (opcode)
                6'h0d: onehot[2]  = 1'b1;
                6'h0f: onehot[3]  = 1'b1;
                6'h08: onehot[4]  = 1'b1;
                6'h23: onehot[5]  = 1'b1;
                6'h21: onehot[6]  = 1'b1;
                6'h20: onehot[7]  = 1'b1;
                6'h2b: onehot[8]  = 1'b1;
                6'h29: onehot[9]  = 1'b1;
                6'h28: onehot[10] = 1'b1;
                6'h04: onehot[11] = 1'b1;
                6'h02: onehot[12] = 1'b1;
                6'h03: onehot[13] = 1'b1;
`ifdef DECODE_EXT_EN
                6'h0c: onehot[21] = 1'b1;
                6'h05: onehot[22] = 1'b1;
`endif
                default: ;
            endcase
        end
        illegal = (onehot == '0);
    end

    // Group classes that share A3/Tuse/Tnew behaviour.
    always_comb begin
        alu_r   = onehot[0] | onehot[1];
        shift   = onehot[16];
        alu_i   = onehot[2] | onehot[4];
        is_lui  = onehot[3];
        load    = onehot[5] | onehot[6] | onehot[7];
        store   = onehot[8] | onehot[9] | onehot[10];
        br      = onehot[11];
        is_jal  = onehot[13];
        is_jalr = onehot[14];
        is_jr   = onehot[15];
`ifdef DECODE_EXT_EN
        alu_r   = alu_r | onehot[17] | onehot[18] | onehot[19] | onehot[20];
        alu_i   = alu_i | onehot[21];
        br      = br | onehot[22];
        shift   = shift | onehot[23];
`endif
    end

    // Destination, Tnew at E, and when each source is first needed.
    always_comb begin
        a3      = '0;
        tnew    = '0;
        use_rs  = 1'b0;
        use_rt  = 1'b0;
        tuse_rs = '0;
        tuse_rt = '0;
        if (alu_r) begin
            a3 = rd; tnew = 2'd1;
            use_rs = 1'b1; tuse_rs = 2'd1;
            use_rt = 1'b1; tuse_rt = 2'd1;
        end
        if (shift) begin
            a3 = rd; tnew = 2'd1;
            use_rt = 1'b1; tuse_rt = 2'd1;
        end
        if (alu_i) begin
            a3 = rt; tnew = 2'd1;
            use_rs = 1'b1; tuse_rs = 2'd1;
        end
        if (is_lui) begin
            a3 = rt; tnew = 2'd1;
        end
        if (load) begin
            a3 = rt; tnew = 2'd2;
            use_rs = 1'b1; tuse_rs = 2'd1;
        end
        if (store) begin
            use_rs = 1'b1; tuse_rs = 2'd1;
            use_rt = 1'b1; tuse_rt = 2'd2;
        end
        if (br) begin
            use_rs = 1'b1;
            use_rt = 1'b1;
        end
        if (is_jal) begin
            a3 = 5'd31;
        end
        if (is_jalr) begin
            a3 = rd;
            use_rs = 1'b1;
        end
        if (is_jr) begin
            use_rs = 1'b1;
        end
        rfwr = (a3 != 5'd0);
    end

    // A producer blocks the head when its result is still further away
    // than the head's first use of that register; $0 never conflicts.
    always_comb begin
        haz_rs = use_rs && (rs != 5'd0) &&
                 ((d_valid && d_rfwr && (d_a3 == rs) && (d_tnew > tuse_rs)) ||
                  (m_wr && (m_a3 == rs) && (m_tnew > tuse_rs)));
        haz_rt = use_rt && (rt != 5'd0) &&
                 ((d_valid && d_rfwr && (d_a3 == rt) && (d_tnew > tuse_rt)) ||
                  (m_wr && (m_a3 == rt) && (m_tnew > tuse_rt)));
        stall  = head_valid && (haz_rs || haz_rt);
    end

    // D/E register: load on pop, drop to a bubble when E takes the entry
    // and nothing replaces it, hold everything while E is not ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_valid   <= 1'b0;
            d_instr   <= '0;
            d_pc      <= '0;
            d_rs      <= '0;
            d_rt      <= '0;
            d_a3      <= '0;
            d_rfwr    <= 1'b0;
            d_tnew    <= '0;
            d_onehot  <= '0;
            d_illegal <= 1'b0;
        end else if (flush) begin
            d_valid <= 1'b0;
        end else if (pop) begin
            d_valid   <= 1'b1;
            d_instr   <= h_instr;
            d_pc      <= mem_pc[rd_ptr];
            d_rs      <= rs;
            d_rt      <= rt;
            d_a3      <= a3;
            d_rfwr    <= rfwr;
            d_tnew    <= tnew;
            d_onehot  <= onehot;
            d_illegal <= illegal;
        end else if (d_ready) begin
            d_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage_buf.sv
// ---------------------------------------------------------------------------
// tb_decode_stage_buf
//
// Directed bench for decode_stage_buf: load-use stall, M-stage branch
// hazard, buffer fill with back-pressure and wrap-around drain, flush,
// jal/jr, the all-zero word, an extension-set encoding and an asynchronous
// reset in the middle of traffic.  Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_decode_stage_buf;

`ifdef DECODE_EXT_EN
    localparam int NINS = 24;
`else
    localparam int NINS = 17;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            f_valid;
    logic            f_ready;
    logic [31:0]     f_instr;
    logic [31:0]     f_pc;
    logic            flush;
    logic            m_wr;
    logic [4:0]      m_a3;
    logic [1:0]      m_tnew;
    logic            d_valid;
    logic            d_ready;
    logic [31:0]     d_instr;
    logic [31:0]     d_pc;
    logic [4:0]      d_rs;
    logic [4:0]      d_rt;
    logic [4:0]      d_a3;
    logic            d_rfwr;
    logic [1:0]      d_tnew;
    logic [NINS-1:0] d_onehot;
    logic            d_illegal;
    logic            stall;

    int errorCount = 0;
    int checkCount = 0;

    // Hand-assembled instruction words.
    localparam logic [31:0] LW_8_0_9    = 32'h8D28_0000;
    localparam logic [31:0] ADDU_10_8_11 = 32'h010B_5021;
    localparam logic [31:0] BEQ_1_2     = 32'h1022_0000;
    localparam logic [31:0] JAL_40      = 32'h0C00_0040;
    localparam logic [31:0] JR_31       = 32'h03E0_0008;
    localparam logic [31:0] NOP_WORD    = 32'h0000_0000;
    localparam logic [31:0] AND_1_2_3   = 32'h0043_0824;

    // ori $k,$0,k for k=1..6; rs is $0 so they never stall.
    logic [31:0] oriWords [6] = '{32'h3401_0001, 32'h3402_0002, 32'h3403_0003,
                                  32'h3404_0004, 32'h3405_0005, 32'h3406_0006};

    decode_stage_buf #(.DEPTH(4), .PC_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .f_valid   (f_valid),
        .f_ready   (f_ready),
        .f_instr   (f_instr),
        .f_pc      (f_pc),
        .flush     (flush),
        .m_wr      (m_wr),
        .m_a3      (m_a3),
        .m_tnew    (m_tnew),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .d_instr   (d_instr),
        .d_pc      (d_pc),
        .d_rs      (d_rs),
        .d_rt      (d_rt),
        .d_a3      (d_a3),
        .d_rfwr    (d_rfwr),
        .d_tnew    (d_tnew),
        .d_onehot  (d_onehot),
        .d_illegal (d_illegal),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives the F-side offer.
    task automatic applyStimulus(input logic valid, input logic [31:0] instr,
                                 input logic [31:0] pc);
        f_valid = valid;
        f_instr = instr;
        f_pc    = pc;
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b0;
        flush   = 1'b0;
        m_wr    = 1'b0;
        m_a3    = 5'd0;
        m_tnew  = 2'd0;
        d_ready = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0);

        #12;
        checkOutput("reset d_valid", d_valid, 0);
        checkOutput("reset f_ready", f_ready, 1);
        checkOutput("reset stall", stall, 0);
        checkOutput("reset d_instr", d_instr, 0);
        checkOutput("reset d_onehot", d_onehot, 0);
        reset = 1'b1;
        nextCycle();

        // Load-use: lw $8 then addu using $8 stalls exactly one cycle.
        applyStimulus(1'b1, LW_8_0_9, 32'h100);
        #1 checkOutput("lw empty no bypass stall", stall, 0);
        nextCycle();
        applyStimulus(1'b1, ADDU_10_8_11, 32'h104);
        #1 checkOutput("lw head no stall", stall, 0);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 32'h0);
        #1;
        checkOutput("lw d_valid", d_valid, 1);
        checkOutput("lw d_instr", d_instr, LW_8_0_9);
        checkOutput("lw d_pc", d_pc, 32'h100);
        checkOutput("lw d_onehot", d_onehot, 64'h1 << 5);
        checkOutput("lw d_a3", d_a3, 8);
        checkOutput("lw d_rfwr", d_rfwr, 1);
        checkOutput("lw d_tnew", d_tnew, 2);
        checkOutput("addu stall cycle1", stall, 1);
        nextCycle();
        checkOutput("load-use bubble", d_valid, 0);
        checkOutput("addu stall cleared", stall, 0);
        nextCycle();
        checkOutput("addu d_valid", d_valid, 1);
        checkOutput("addu d_onehot", d_onehot, 64'h1);
        checkOutput("addu d_a3", d_a3, 10);
        checkOutput("addu d_rs", d_rs, 8);
        checkOutput("addu d_rt", d_rt, 11);
        checkOutput("addu d_tnew", d_tnew, 1);
        nextCycle();
        checkOutput("after addu bubble", d_valid, 0);

        // beq against an M-stage producer of $1 with Tnew 1.
        m_wr   = 1'b1;
        m_a3   = 5'd1;
        m_tnew = 2'd1;
        applyStimulus(1'b1, BEQ_1_2, 32'h200);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 32'h0);
        #1 checkOutput("beq stall m_tnew1", stall, 1);
        nextCycle();
        checkOutput("beq still stalled", stall, 1);
        checkOutput("beq held back", d_valid, 0);
        m_tnew = 2'd0;
        #1 checkOutput("beq stall m_tnew0", stall, 0);
        nextCycle();
        checkOutput("beq d_valid", d_valid, 1);
        checkOutput("beq d_onehot", d_onehot, 64'h1 << 11);
        checkOutput("beq d_rfwr", d_rfwr, 0);
        m_wr = 1'b0;
        nextCycle();

        // Fill: 4 buffered + 1 in D/E while E is not ready.
        d_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, oriWords[i], 32'h300 + 32'(4 * i));
            #1 checkOutput($sformatf("fill f_ready %0d", i), f_ready, 1);
            nextCycle();
        end
        applyStimulus(1'b1, oriWords[5], 32'h314);
        #1 checkOutput("full f_ready", f_ready, 0);
        nextCycle();
        checkOutput("full hold d_instr", d_instr, oriWords[0]);
        checkOutput("full hold d_valid", d_valid, 1);
        d_ready = 1'b1;
        #1 checkOutput("full f_ready during pop", f_ready, 0);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 32'h0);
        for (int i = 1; i < 5; i++) begin
            checkOutput($sformatf("drain d_instr %0d", i), d_instr, oriWords[i]);
            checkOutput($sformatf("drain d_valid %0d", i), d_valid, 1);
            nextCycle();
        end
        checkOutput("drained d_valid", d_valid, 0);
        checkOutput("drained f_ready", f_ready, 1);

        // Flush with three buffered entries and a word on offer.
        d_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, oriWords[i], 32'h400 + 32'(4 * i));
            nextCycle();
        end
        checkOutput("pre-flush d_valid", d_valid, 1);
        flush = 1'b1;
        applyStimulus(1'b1, oriWords[5], 32'h414);
        nextCycle();
        flush   = 1'b0;
        d_ready = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0);
        checkOutput("flush d_valid", d_valid, 0);
        checkOutput("flush f_ready", f_ready, 1);
        checkOutput("flush stall", stall, 0);
        nextCycle();
        checkOutput("flushed word absent", d_valid, 0);

        // jal then jr $31: no stall, jr writes nothing.
        applyStimulus(1'b1, JAL_40, 32'h500);
        nextCycle();
        applyStimulus(1'b1, JR_31, 32'h504);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 32'h0);
        #1;
        checkOutput("jal d_instr", d_instr, JAL_40);
        checkOutput("jal d_a3", d_a3, 31);
        checkOutput("jal d_tnew", d_tnew, 0);
        checkOutput("jal d_rfwr", d_rfwr, 1);
        checkOutput("jal d_onehot", d_onehot, 64'h1 << 13);
        checkOutput("jr stall", stall, 0);
        nextCycle();
        checkOutput("jr d_valid", d_valid, 1);
        checkOutput("jr d_onehot", d_onehot, 64'h1 << 15);
        checkOutput("jr d_rfwr", d_rfwr, 0);
        checkOutput("jr d_rs", d_rs, 31);

        // All-zero word, then and $1,$2,$3.
        applyStimulus(1'b1, NOP_WORD, 32'h600);
        nextCycle();
        applyStimulus(1'b1, AND_1_2_3, 32'h604);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 32'h0);
        checkOutput("nop d_pc", d_pc, 32'h600);
        checkOutput("nop d_rfwr", d_rfwr, 0);
        checkOutput("nop d_illegal", d_illegal, 0);
        checkOutput("nop d_onehot", d_onehot, 64'h1 << 16);
        nextCycle();
        checkOutput("and d_valid", d_valid, 1);
`ifdef DECODE_EXT_EN
        checkOutput("and d_illegal", d_illegal, 0);
        checkOutput("and d_onehot", d_onehot, 64'h1 << 17);
        checkOutput("and d_rfwr", d_rfwr, 1);
`else
        checkOutput("and d_illegal", d_illegal, 1);
        checkOutput("and d_onehot", d_onehot, 0);
        checkOutput("and d_rfwr", d_rfwr, 0);
`endif
        nextCycle();

        // Asynchronous reset in the middle of traffic.
        d_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, oriWords[i], 32'h700 + 32'(4 * i));
            nextCycle();
        end
        applyStimulus(1'b0, 32'h0, 32'h0);
        checkOutput("pre-reset d_valid", d_valid, 1);
        #2 reset = 1'b0;
        #1;
        checkOutput("async reset d_valid", d_valid, 0);
        checkOutput("async reset d_instr", d_instr, 0);
        checkOutput("async reset f_ready", f_ready, 1);
        checkOutput("async reset stall", stall, 0);
        #3 reset = 1'b1;
        nextCycle();

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
